// File: rtl/pad_link_tx.sv
// pad_link_tx: UART-style transmitter that sends synchronized button state plus a 3-bit sequence number per frame.
module pad_link_tx #(
  parameter int unsigned BIT_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       left,
  input  logic       right,
  input  logic       attack,
  input  logic       send,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [2:0] seq
);
  localparam int CW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] idx, idx_n;
  logic [7:0] data, data_n, nb;
  logic [6:0] d7;
  logic [2:0] seq_n, s1, s2;
  logic pend, pend_n, tx_n, busy_n, done_n, bit_end, go;
  assign bit_end = cnt == CW'(BIT_DIV - 1);
  assign d7 = {1'b0, seq + 3'd1, s2};
  assign nb = {^d7, d7};
  always_comb begin
    state_n = state;
    cnt_n = (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
    idx_n = idx;
    data_n = data;
    seq_n = seq;
    pend_n = pend | (state != IDLE && send);
    tx_n = tx;
    busy_n = busy;
    done_n = 1'b0;
    go = 1'b0;
    case (state)
      IDLE: go = send;
      START: if (bit_end) begin
        state_n = DATA;
        idx_n = '0;
        tx_n = data[0];
      end
      DATA: if (bit_end) begin
        if (idx == 4'd7) begin
          state_n = STOP;
          tx_n = 1'b1;
        end else begin
          idx_n = idx + 4'd1;
          tx_n = data[idx[2:0] + 3'd1];
        end
      end
      STOP: if (bit_end) begin
        done_n = 1'b1;
        go = pend | send;
        pend_n = 1'b0;
        state_n = IDLE;
        busy_n = 1'b0;
        tx_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    // A new frame latches buttons and the next sequence number on the start edge
    if (go) begin
      state_n = START;
      seq_n = seq + 3'd1;
      data_n = nb;
      tx_n = 1'b0;
      busy_n = 1'b1;
      cnt_n = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      data <= '0;
      seq <= '0;
      pend <= 1'b0;
      tx <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      s1 <= '0;
      s2 <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      data <= data_n;
      seq <= seq_n;
      pend <= pend_n;
      tx <= tx_n;
      busy <= busy_n;
      done <= done_n;
      s1 <= {attack, right, left};
      s2 <= s1;
    end
  end
endmodule
